// File: rtl/reg_display.sv
// Register viewer: debounced next/prev buttons select a core register whose 32-bit value is
// shown as eight hex digits on a multiplexed active-low seven-segment display.
module reg_display #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  output logic [4:0]  reg_out_id,
  input  logic [31:0] reg_out_data,
  output logic [6:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned DbW  = $clog2(DEBOUNCE);
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE - 1);

  // Index 0 is btn_next, index 1 is btn_prev.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          level_q, level_d;
  logic [1:0][DbW-1:0] cnt_q, cnt_d;
  logic [1:0]          press_q, press_d;
  logic [4:0]          id_q, id_d;

  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      an_q, an_d;
  logic            tick, wrap;
  logic [3:0]      nibble;

  assign btn_raw = {btn_prev, btn_next};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Press pulse fires only when the debounced level is accepted as 1.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DbLast) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        press_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    id_d = id_q;
    case (press_q)
      2'b01:   id_d = id_q + 5'd1;
      2'b10:   id_d = id_q - 5'd1;
      default: id_d = id_q;
    endcase
  end

  always_comb begin
    tick     = (pre_q == PreLast);
    wrap     = tick && (idx_q == 3'd7);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = wrap ? reg_out_data : shadow_q;
    // Digit 0 of a new frame shows the word being captured on this same edge.
    nibble   = wrap ? reg_out_data[3:0] : shadow_q[{idx_d, 2'b00} +: 4];
    seg_d    = tick ? hex_to_seg(nibble) : seg_q;
    an_d     = tick ? ~(8'b1 << idx_d) : an_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      id_q     <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= 7'h40;
      an_q     <= 8'hFE;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      id_q     <= id_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign reg_out_id = id_q;
  assign seg_n      = seg_q;
  assign an_n       = an_q;

endmodule

// File: tb/tb_reg_display.sv
// Directed bench for reg_display with SCAN_DIV=4, DEBOUNCE=3: scan order, frame
// consistency, debounce, id wrap, simultaneous presses and asynchronous reset.
module tb_reg_display;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_next;
  logic        btn_prev;
  logic [4:0]  reg_out_id;
  logic [31:0] reg_out_data;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;

  int n_cmp = 0;
  int n_err = 0;

  reg_display #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .reg_out_id  (reg_out_id),
    .reg_out_data(reg_out_data),
    .seg_n       (seg_n),
    .an_n        (an_n)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic hold_btn(input logic nxt, input logic prv, input int cycles);
    @(negedge clock);
    btn_next = nxt;
    btn_prev = prv;
    repeat (cycles) @(negedge clock);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    logic [31:0] shadow_m;
    logic [7:0]  an_e;
    logic [6:0]  seg_e;
    int          digit;

    reset        = 1'b1;
    btn_next     = 1'b0;
    btn_prev     = 1'b0;
    reg_out_data = 32'h89AB_CDEF;
    #2;
    check_eq("rst_an", an_n, 8'hFE);
    check_eq("rst_seg", seg_n, 7'h40);
    check_eq("rst_id", reg_out_id, 5'd0);

    // Reset released at a negedge; edge n is the n-th posedge after that.
    @(negedge clock);
    reset    = 1'b0;
    shadow_m = 32'h0;
    for (int n = 1; n <= 128; n++) begin
      @(negedge clock);
      if (n % 32 == 0) shadow_m = reg_out_data;
      digit = (n % 32) / 4;
      an_e  = ~(8'b1 << digit);
      seg_e = exp_seg(shadow_m[digit*4 +: 4]);
      check_eq($sformatf("scan_an_%0d", n), an_n, an_e);
      check_eq($sformatf("scan_seg_%0d", n), seg_n, seg_e);
      if (n == 76) reg_out_data = 32'h0123_4567;
    end

    check_eq("id_idle", reg_out_id, 5'd0);
    hold_btn(1'b1, 1'b0, 2);
    check_eq("short_press", reg_out_id, 5'd0);

    @(negedge clock);
    btn_next = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("held_once", reg_out_id, 5'd1);
    btn_next = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("released", reg_out_id, 5'd1);

    hold_btn(1'b1, 1'b0, 10);
    check_eq("next_2", reg_out_id, 5'd2);
    hold_btn(1'b0, 1'b1, 10);
    check_eq("prev_1", reg_out_id, 5'd1);
    hold_btn(1'b0, 1'b1, 10);
    check_eq("prev_0", reg_out_id, 5'd0);
    hold_btn(1'b0, 1'b1, 10);
    check_eq("prev_wrap", reg_out_id, 5'd31);
    hold_btn(1'b1, 1'b0, 10);
    check_eq("next_wrap", reg_out_id, 5'd0);
    hold_btn(1'b1, 1'b0, 10);
    check_eq("next_1", reg_out_id, 5'd1);
    hold_btn(1'b1, 1'b1, 10);
    check_eq("both", reg_out_id, 5'd1);
    hold_btn(1'b1, 1'b0, 10);
    check_eq("next_3rd", reg_out_id, 5'd2);

    // Wait until a non-zero digit is lit so the async reset visibly changes outputs.
    for (int k = 0; k < 40 && an_n == 8'hFE; k++) @(negedge clock);
    check_eq("pre_rst_an_not_fe", 32'(an_n != 8'hFE), 32'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_eq("async_rst_an", an_n, 8'hFE);
    check_eq("async_rst_seg", seg_n, 7'h40);
    check_eq("async_rst_id", reg_out_id, 5'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("post_rst_id", reg_out_id, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
